// File: rtl/sprite_motion_fsm.sv
// Per-frame sprite motion controller: GROUND/AIR/CLIMB state machine with
// collision/jump latching between frame ticks and a clamped fixed-point position.
module sprite_motion_fsm #(
    parameter int INIT_X      = 280,
    parameter int INIT_Y      = 185,
    parameter int FP_SHIFT    = 6,
    parameter int WALK_SPEED  = 40,
    parameter int CLIMB_SPEED = 40,
    parameter int JUMP_SPEED  = -300,
    parameter int GRAVITY     = 5,
    parameter int MAX_FALL    = 230,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 575,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 415,
    parameter int COORD_W     = 11
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      startOfFrame,
    input  logic                      leftReq,
    input  logic                      rightReq,
    input  logic                      upReq,
    input  logic                      downReq,
    input  logic                      jumpReq,
    input  logic                      wallCollision,
    input  logic                      ladderCollision,
    input  logic [3:0]                HitEdgeCode,
    output logic signed [COORD_W-1:0] topLeftX,
    output logic signed [COORD_W-1:0] topLeftY,
    output logic [1:0]                state,
    output logic                      facingLeft,
    output logic                      onGround
);

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        AIR    = 2'd1,
        CLIMB  = 2'd2
    } state_t;

    localparam int FP_ONE = 2 ** FP_SHIFT;
    localparam logic signed [31:0] X_LO   = 32'(X_MIN * FP_ONE);
    localparam logic signed [31:0] X_HI   = 32'(X_MAX * FP_ONE);
    localparam logic signed [31:0] Y_LO   = 32'(Y_MIN * FP_ONE);
    localparam logic signed [31:0] Y_HI   = 32'(Y_MAX * FP_ONE);
    localparam logic signed [31:0] X_RST  = 32'(INIT_X * FP_ONE);
    localparam logic signed [31:0] Y_RST  = 32'(INIT_Y * FP_ONE);
    localparam logic signed [31:0] WALK   = 32'(WALK_SPEED);
    localparam logic signed [31:0] CLIMBV = 32'(CLIMB_SPEED);
    localparam logic signed [31:0] JUMPV  = 32'(JUMP_SPEED);
    localparam logic signed [31:0] GRAV   = 32'(GRAVITY);
    localparam logic signed [31:0] FALLV  = 32'(MAX_FALL);

    state_t             stateR, stateN;
    logic signed [31:0] fixX, fixY, xSpeed, ySpeed;
    logic signed [31:0] fixXN, fixYN, xSpeedN, ySpeedN;
    logic signed [31:0] xRaw, xSum, ySum;
    logic               faceN;

    logic hitL, hitR, hitT, hitB, onLadder, jumpPend, jumpPrev;
    logic setL, setR, setT, setB, setLad, jumpEdge;
    logic effL, effR, effT, effB, effLad, effJump;

    // A corner hit simply asserts several edge bits, so per-bit gating covers it.
    assign setL     = wallCollision & HitEdgeCode[3];
    assign setT     = wallCollision & HitEdgeCode[2];
    assign setR     = wallCollision & HitEdgeCode[1];
    assign setB     = wallCollision & HitEdgeCode[0];
    assign setLad   = ladderCollision;
    assign jumpEdge = jumpReq & ~jumpPrev;

    assign effL    = hitL | setL;
    assign effR    = hitR | setR;
    assign effT    = hitT | setT;
    assign effB    = hitB | setB;
    assign effLad  = onLadder | setLad;
    assign effJump = jumpPend | jumpEdge;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            jumpPrev <= 1'b0;
            hitL     <= 1'b0;
            hitR     <= 1'b0;
            hitT     <= 1'b0;
            hitB     <= 1'b0;
            onLadder <= 1'b0;
            jumpPend <= 1'b0;
        end else begin
            jumpPrev <= jumpReq;
            if (startOfFrame) begin
                hitL     <= 1'b0;
                hitR     <= 1'b0;
                hitT     <= 1'b0;
                hitB     <= 1'b0;
                onLadder <= 1'b0;
                jumpPend <= 1'b0;
            end else begin
                hitL     <= hitL | setL;
                hitR     <= hitR | setR;
                hitT     <= hitT | setT;
                hitB     <= hitB | setB;
                onLadder <= onLadder | setLad;
                jumpPend <= jumpPend | jumpEdge;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            stateR     <= AIR;
            fixX       <= X_RST;
            fixY       <= Y_RST;
            xSpeed     <= '0;
            ySpeed     <= '0;
            facingLeft <= 1'b0;
        end else if (startOfFrame) begin
            stateR     <= stateN;
            fixX       <= fixXN;
            fixY       <= fixYN;
            xSpeed     <= xSpeedN;
            ySpeed     <= ySpeedN;
            facingLeft <= faceN;
        end
    end

    always_comb begin
        stateN  = stateR;
        ySpeedN = ySpeed;
        xSpeedN = xSpeed;
        fixXN   = fixX;
        fixYN   = fixY;
        faceN   = facingLeft;
        xRaw    = '0;
        xSum    = '0;
        ySum    = '0;

        if (leftReq && !rightReq) begin
            xRaw  = -WALK;
            faceN = 1'b1;
        end else if (rightReq && !leftReq) begin
            xRaw  = WALK;
            faceN = 1'b0;
        end
        if (effL && xRaw < 0) xRaw = '0;
        if (effR && xRaw > 0) xRaw = '0;

        case (stateR)
            GROUND: begin
                ySpeedN = '0;
                if (effJump) begin
                    stateN  = AIR;
                    ySpeedN = JUMPV;
                end else if (effLad && (upReq || downReq)) begin
                    stateN = CLIMB;
                end else if (!effB && fixY < Y_HI) begin
                    stateN = AIR;
                end
            end
            AIR: begin
                if (effLad && upReq) begin
                    stateN  = CLIMB;
                    ySpeedN = '0;
                end else if ((effB && ySpeed >= 0) || fixY >= Y_HI) begin
                    stateN  = GROUND;
                    ySpeedN = '0;
                end else if (effT && ySpeed < 0) begin
                    ySpeedN = '0;
                end else if (ySpeed + GRAV > FALLV) begin
                    ySpeedN = FALLV;
                end else begin
                    ySpeedN = ySpeed + GRAV;
                end
            end
            CLIMB: begin
                ySpeedN = '0;
                if (effJump) begin
                    stateN  = AIR;
                    ySpeedN = JUMPV;
                end else if (!effLad) begin
                    stateN = AIR;
                end else if (effB && downReq) begin
                    stateN = GROUND;
                end else begin
                    if (upReq && !downReq) ySpeedN = -CLIMBV;
                    else if (downReq && !upReq) ySpeedN = CLIMBV;
                    if (effT && ySpeedN < 0) ySpeedN = '0;
                end
            end
            default: stateN = AIR;
        endcase

        // Horizontal motion is frozen for any frame that ends on the ladder.
        xSpeedN = (stateN == CLIMB) ? '0 : xRaw;

        xSum = fixX + xSpeedN;
        if (xSum <= X_LO) begin
            fixXN   = X_LO;
            xSpeedN = '0;
        end else if (xSum >= X_HI) begin
            fixXN   = X_HI;
            xSpeedN = '0;
        end else begin
            fixXN = xSum;
        end

        ySum = fixY + ySpeedN;
        if (ySum < Y_LO)      fixYN = Y_LO;
        else if (ySum > Y_HI) fixYN = Y_HI;
        else                  fixYN = ySum;
    end

    assign topLeftX = COORD_W'(fixX >>> FP_SHIFT);
    assign topLeftY = COORD_W'(fixY >>> FP_SHIFT);
    assign state    = stateR;
    assign onGround = (stateR == GROUND);

endmodule

// File: tb/tb_sprite_motion_fsm.sv
// Directed bench for sprite_motion_fsm: hand-computed positions/states per frame tick.
module tb_sprite_motion_fsm;

    logic               clk = 1'b0;
    logic               resetN = 1'b0;
    logic               startOfFrame = 1'b0;
    logic               leftReq = 1'b0, rightReq = 1'b0, upReq = 1'b0, downReq = 1'b0;
    logic               jumpReq = 1'b0;
    logic               wallCollision = 1'b0, ladderCollision = 1'b0;
    logic [3:0]         HitEdgeCode = 4'b0000;
    logic signed [10:0] topLeftX, topLeftY;
    logic [1:0]         state;
    logic               facingLeft, onGround;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sprite_motion_fsm dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .leftReq(leftReq), .rightReq(rightReq), .upReq(upReq), .downReq(downReq),
        .jumpReq(jumpReq), .wallCollision(wallCollision), .ladderCollision(ladderCollision),
        .HitEdgeCode(HitEdgeCode), .topLeftX(topLeftX), .topLeftY(topLeftY),
        .state(state), .facingLeft(facingLeft), .onGround(onGround)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) startOfFrame = 1'b1;
            @(negedge clk) startOfFrame = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk) resetN = 1'b0;
        {leftReq, rightReq, upReq, downReq, jumpReq} = '0;
        {wallCollision, ladderCollision} = '0;
        HitEdgeCode = 4'b0000;
        @(negedge clk) resetN = 1'b1;
    endtask

    task automatic pulse_jump();
        @(negedge clk) jumpReq = 1'b1;
        @(negedge clk) jumpReq = 1'b0;
    endtask

    // Reset followed by one tick standing on the floor: GROUND at fixed Y 11840.
    task automatic land();
        do_reset();
        wallCollision = 1'b1;
        HitEdgeCode   = 4'b0001;
        tick(1);
    endtask

    initial begin
        do_reset();
        chk("rst_x", topLeftX, 280);
        chk("rst_y", topLeftY, 185);
        chk("rst_state", state, 1);
        chk("rst_ground", onGround, 0);
        chk("rst_face", facingLeft, 0);
        tick(1);
        chk("t1_x", topLeftX, 280);
        chk("t1_y", topLeftY, 185);
        chk("t1_state", state, 1);

        // Walking on the floor
        land();
        chk("land_state", state, 0);
        chk("land_ground", onGround, 1);
        rightReq = 1'b1;
        tick(8);
        chk("walk_r_x", topLeftX, 285);
        chk("walk_r_face", facingLeft, 0);
        rightReq = 1'b0;
        leftReq  = 1'b1;
        tick(8);
        chk("walk_l_x", topLeftX, 280);
        chk("walk_l_face", facingLeft, 1);
        leftReq = 1'b0;

        // Jump, then a second jump press mid-air that must be ignored
        pulse_jump();
        tick(1);
        chk("jump_state", state, 1);
        chk("jump_y1", topLeftY, 180);
        wallCollision = 1'b0;
        HitEdgeCode   = 4'b0000;
        tick(1);
        chk("jump_y2", topLeftY, 175);
        pulse_jump();
        tick(1);
        chk("jump_air_y3", topLeftY, 171);
        chk("jump_air_state", state, 1);

        // Right wall (corner with floor) blocks rightward walking only
        land();
        wallCollision = 1'b1;
        HitEdgeCode   = 4'b0011;
        rightReq      = 1'b1;
        tick(10);
        chk("wall_r_x", topLeftX, 280);
        chk("wall_r_state", state, 0);
        rightReq = 1'b0;
        leftReq  = 1'b1;
        tick(1);
        chk("wall_l_x", topLeftX, 279);
        chk("wall_l_face", facingLeft, 1);
        leftReq = 1'b0;

        // Free fall: speed saturates at tick 46, lands on the Y clamp
        do_reset();
        tick(45);
        chk("fall45_y", topLeftY, 265);
        tick(1);
        chk("fall46_y", topLeftY, 269);
        tick(14);
        chk("fall60_y", topLeftY, 319);
        chk("fall60_state", state, 1);
        tick(26);
        chk("fall86_y", topLeftY, 413);
        tick(1);
        chk("fall87_y", topLeftY, 415);
        chk("fall87_state", state, 1);
        tick(1);
        chk("fall88_state", state, 0);
        chk("fall88_y", topLeftY, 415);

        // Ladder climbing with X frozen, then dropping off
        land();
        ladderCollision = 1'b1;
        upReq           = 1'b1;
        tick(1);
        chk("ladder_state", state, 2);
        chk("ladder_y0", topLeftY, 185);
        wallCollision = 1'b0;
        HitEdgeCode   = 4'b0000;
        rightReq      = 1'b1;
        tick(1);
        chk("climb_y1", topLeftY, 184);
        chk("climb_x1", topLeftX, 280);
        tick(1);
        chk("climb_y2", topLeftY, 183);
        chk("climb_state", state, 2);
        ladderCollision = 1'b0;
        upReq           = 1'b0;
        rightReq        = 1'b0;
        tick(1);
        chk("drop_state", state, 1);
        chk("drop_y", topLeftY, 183);
        tick(1);
        chk("drop_y2", topLeftY, 183);
        chk("drop_state2", state, 1);

        // Right edge of the play window
        land();
        rightReq = 1'b1;
        tick(480);
        chk("xmax_x", topLeftX, 575);
        rightReq = 1'b0;
        leftReq  = 1'b1;
        tick(1);
        chk("xmax_back", topLeftX, 574);
        leftReq = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
